pp_mult_scheduler: RTL

//  Sequential 8x8 unsigned multiplier controller built around the shared 64-bit

---
 rtl/mult_pkg.sv | 14 +
 rtl/ANDoperator.sv | 14 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/pp_mult_scheduler.sv | 133 +++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and widths for the partial-product multiplier scheduler.
package mult_pkg;

    localparam int OP_W   = 8;
    localparam int PP_W   = 64;
    localparam int PROD_W = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } mult_state_t;

endpackage

// File: rtl/ANDoperator.sv
// 8x8 partial-product array: bit 8*j+i is A[i] & B[j], so row j is A gated by B[j].
module ANDoperator (
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic [63:0] Out
);

    for (genvar j = 0; j < 8; j++) begin : g_row
        for (genvar i = 0; i < 8; i++) begin : g_col
            assign Out[8*j+i] = A[i] & B[j];
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    logic [IDW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int off = 0; off < NREQ; off++) begin
            cand = IDW'((int'(ptr) + off) % NREQ);
            if (!any && req[cand]) begin
                any         = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pp_mult_scheduler.sv
// Round-robin scheduled sequential 8x8 multiplier that sums partial-product rows
// of a latched operand pair and returns the product tagged with the requester id.
//
//  state  | meaning
//  S_IDLE | arbitrate requesters, latch granted operands on handshake
//  S_RUN  | add ROWS_PER_CYC shifted partial-product rows per cycle
//  S_DONE | hold product/id with res_valid until res_ready
module pp_mult_scheduler
    import mult_pkg::*;
#(
    parameter  int NREQ         = 2,
    parameter  int ROWS_PER_CYC = 1,
    localparam int IDW          = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*OP_W-1:0] req_a,
    input  logic [NREQ*OP_W-1:0] req_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [PROD_W-1:0]    res_product,
    output logic [IDW-1:0]       res_id,
    output logic                 busy
);

    mult_state_t       state, state_nxt;
    logic [OP_W-1:0]   a_q, b_q;
    logic [IDW-1:0]    id_q, rr_ptr, ptr_nxt, gnt_idx;
    logic [NREQ-1:0]   gnt;
    logic              gnt_any, accept, last;
    logic [PROD_W-1:0] acc, acc_nxt, step_sum;
    logic [3:0]        row, row_nxt, rk;
    logic [PP_W-1:0]   pp;
    logic [OP_W-1:0]   pp_row [8];
    logic [OP_W-1:0]   op_a [NREQ];
    logic [OP_W-1:0]   op_b [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_ops
        assign op_a[i] = req_a[OP_W*i +: OP_W];
        assign op_b[i] = req_b[OP_W*i +: OP_W];
    end

    for (genvar j = 0; j < 8; j++) begin : g_rows
        assign pp_row[j] = pp[OP_W*j +: OP_W];
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (gnt),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    ANDoperator u_pp (
        .A   (a_q),
        .B   (b_q),
        .Out (pp)
    );

    // Ready is masked during reset so no requester sees an accept that is then discarded.
    assign req_ready = (state == S_IDLE && !rst) ? gnt : '0;
    assign accept    = (state == S_IDLE) && gnt_any;
    assign ptr_nxt   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
    assign res_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

    always_comb begin
        step_sum = '0;
        rk       = row;
        for (int k = 0; k < ROWS_PER_CYC; k++) begin
            rk       = row + 4'(k);
            step_sum = step_sum + ({8'b0, pp_row[rk[2:0]]} << rk);
        end
    end

    assign acc_nxt = acc + step_sum;
    assign row_nxt = row + 4'(ROWS_PER_CYC);
    assign last    = (state == S_RUN) && (row_nxt == 4'd8);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_RUN;
            S_RUN:   if (last) state_nxt = S_DONE;
            S_DONE:  if (res_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            acc         <= '0;
            row         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            res_product <= '0;
            res_id      <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_q    <= op_a[gnt_idx];
                        b_q    <= op_b[gnt_idx];
                        id_q   <= gnt_idx;
                        acc    <= '0;
                        row    <= '0;
                        rr_ptr <= ptr_nxt;
                    end
                end
                S_RUN: begin
                    acc <= acc_nxt;
                    row <= row_nxt;
                    if (last) begin
                        res_product <= acc_nxt;
                        res_id      <= id_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
